// File: rtl/movimento_rettangolo_pkg.sv
// Shared constants and types for the sprite-motion block and the hit-test blocks
// that consume its anchor.
package movimento_rettangolo_pkg;

    localparam int H       = 1280;
    localparam int V       = 1024;
    localparam int POS_W   = 11;
    localparam int ARITH_W = 12;
    localparam int SPEED_W = 4;

    typedef enum logic [1:0] {
        FERMO  = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } stato_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

endpackage

// File: rtl/movimento_rettangolo_if.sv
// Frame-tick, button and position signals between the motion block and its driver.
interface movimento_rettangolo_if;
    import movimento_rettangolo_pkg::*;

    logic             frame_tick;
    logic             btn_left;
    logic             btn_right;
    logic             btn_up;
    logic             btn_down;
    logic             pause;
    logic [POS_W-1:0] x_pos;
    logic [POS_W-1:0] y_pos;
    logic             moving;
    logic             wrap_x;

    modport master (
        output frame_tick, btn_left, btn_right, btn_up, btn_down, pause,
        input  x_pos, y_pos, moving, wrap_x
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_up, btn_down, pause,
        output x_pos, y_pos, moving, wrap_x
    );

endinterface

// File: rtl/movimento_rettangolo_somma_modulo.sv
// Combinational (x +/- d) mod H for the horizontal anchor, flagging when the
// result wrapped around either edge of the line.
module somma_modulo
    import movimento_rettangolo_pkg::*;
(
    input  logic [POS_W-1:0]   x,
    input  logic [SPEED_W-1:0] d,
    input  dir_t               dir,
    output logic [POS_W-1:0]   y,
    output logic               wrap
);

    localparam logic [ARITH_W-1:0] H_W = ARITH_W'(H);

    logic [ARITH_W-1:0] x_w;
    logic [ARITH_W-1:0] d_w;
    logic [ARITH_W-1:0] sum;
    logic [ARITH_W-1:0] res;

    assign x_w = ARITH_W'(x);
    assign d_w = ARITH_W'(d);
    assign sum = x_w + d_w;

    always_comb begin
        res  = '0;
        wrap = 1'b0;
        if (dir == DIR_RIGHT) begin
            if (sum >= H_W) begin
                res  = sum - H_W;
                wrap = 1'b1;
            end else begin
                res = sum;
            end
        end else if (x_w < d_w) begin
            res  = x_w + H_W - d_w;
            wrap = 1'b1;
        end else begin
            res = x_w - d_w;
        end
    end

    assign y = POS_W'(res);

endmodule

// File: rtl/movimento_rettangolo.sv
// Sprite anchor motion: X accelerates/cruises/decelerates and wraps, Y steps and clamps,
// both updated once per unpaused frame tick.
//
// state  | meaning
// FERMO  | stationary, speed 0
// ACCEL  | speed rising one step every ACC_FRAMES frames while dir is held
// CRUISE | speed held at VMAX while dir is held
// DECEL  | speed falling by one per frame until 0
module movimento_rettangolo
    import movimento_rettangolo_pkg::*;
#(
    parameter int ALTEZZA    = 100,
    parameter int X_INIT     = 590,
    parameter int Y_INIT     = 462,
    parameter int VMAX       = 8,
    parameter int ACC_FRAMES = 4,
    parameter int STEP_Y     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    movimento_rettangolo_if.slave  bus
);

    localparam int ACC_W = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;
    localparam logic [ACC_W-1:0]   ACC_LAST  = ACC_W'(ACC_FRAMES - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(VMAX);
    localparam logic [SPEED_W-1:0] SPEED_ONE = SPEED_W'(1);
    localparam logic [ARITH_W-1:0] Y_MAX     = ARITH_W'(V - ALTEZZA);
    localparam logic [ARITH_W-1:0] Y_STEP    = ARITH_W'(STEP_Y);

    stato_t             state, state_nxt;
    dir_t               dir, dir_nxt, req_dir;
    logic [SPEED_W-1:0] speed, speed_nxt, speed_dn;
    logic [ACC_W-1:0]   acc_cnt, acc_nxt;
    logic [POS_W-1:0]   x_q, y_q, x_sum, y_nxt;
    logic [ARITH_W-1:0] y_w, y_down;
    logic               moving_q, wrap_q, wrap_sum;
    logic               evt, req_any, req_same;

    assign evt      = bus.frame_tick & ~bus.pause;
    assign req_any  = bus.btn_left ^ bus.btn_right;
    assign req_dir  = bus.btn_left ? DIR_LEFT : DIR_RIGHT;
    assign req_same = req_any && (req_dir == dir);
    assign speed_dn = speed - SPEED_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FERMO;
            speed    <= '0;
            acc_cnt  <= '0;
            dir      <= DIR_RIGHT;
            x_q      <= POS_W'(X_INIT);
            y_q      <= POS_W'(Y_INIT);
            moving_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (evt) begin
                state    <= state_nxt;
                speed    <= speed_nxt;
                acc_cnt  <= acc_nxt;
                dir      <= dir_nxt;
                x_q      <= x_sum;
                y_q      <= y_nxt;
                moving_q <= (state_nxt != FERMO);
                wrap_q   <= wrap_sum;
            end
        end
    end

    // Speed is settled first; X then moves by the new speed in the new direction.
    always_comb begin
        state_nxt = state;
        speed_nxt = speed;
        acc_nxt   = acc_cnt;
        dir_nxt   = dir;
        case (state)
            FERMO: begin
                if (req_any) begin
                    dir_nxt   = req_dir;
                    speed_nxt = SPEED_ONE;
                    acc_nxt   = '0;
                    state_nxt = (SPEED_MAX == SPEED_ONE) ? CRUISE : ACCEL;
                end
            end
            ACCEL: begin
                if (req_same) begin
                    if (acc_cnt == ACC_LAST) begin
                        speed_nxt = speed + SPEED_ONE;
                        acc_nxt   = '0;
                        if (speed_nxt == SPEED_MAX) state_nxt = CRUISE;
                    end else begin
                        acc_nxt = acc_cnt + 1'b1;
                    end
                end else begin
                    speed_nxt = speed_dn;
                    state_nxt = (speed_dn == '0) ? FERMO : DECEL;
                end
            end
            CRUISE: begin
                if (!req_same) begin
                    speed_nxt = speed_dn;
                    state_nxt = (speed_dn == '0) ? FERMO : DECEL;
                end
            end
            DECEL: begin
                if (req_same) begin
                    state_nxt = ACCEL;
                    acc_nxt   = '0;
                end else begin
                    speed_nxt = speed_dn;
                    if (speed_dn == '0) state_nxt = FERMO;
                end
            end
            default: state_nxt = FERMO;
        endcase
    end

    somma_modulo u_somma (
        .x    (x_q),
        .d    (speed_nxt),
        .dir  (dir_nxt),
        .y    (x_sum),
        .wrap (wrap_sum)
    );

    always_comb begin
        y_w    = ARITH_W'(y_q);
        y_down = y_w + Y_STEP;
        y_nxt  = y_q;
        if (bus.btn_up && !bus.btn_down) begin
            y_nxt = (y_w < Y_STEP) ? '0 : POS_W'(y_w - Y_STEP);
        end else if (bus.btn_down && !bus.btn_up) begin
            y_nxt = (y_down > Y_MAX) ? POS_W'(Y_MAX) : POS_W'(y_down);
        end
    end

    assign bus.x_pos  = x_q;
    assign bus.y_pos  = y_q;
    assign bus.moving = moving_q;
    assign bus.wrap_x = wrap_q;

    a_x_range:  assert property (@(posedge clk) disable iff (rst) x_q < POS_W'(H));
    a_y_range:  assert property (@(posedge clk) disable iff (rst) y_q <= POS_W'(V - ALTEZZA));
    a_speed:    assert property (@(posedge clk) disable iff (rst) speed <= SPEED_MAX);
    a_stopped:  assert property (@(posedge clk) disable iff (rst) (speed == '0) == (state == FERMO));

endmodule
